tabulate_stream_checker: RTL

Receive-side checker for tabulated 2D Vec traffic. A generator streams one element per handshake in row-major order (row 0 col 0, row 0 col 1, ...). This block consumes the stream and checks each element against the tabulate function row+col+BASE. It reports the error count, the first mismatch, last-flag consistency and a final pass/done verdict. It sits in the test harness as the sink paired with the tabulate stream generator.

---
 rtl/tabulate_stream_checker_if.sv | 35 +++
 rtl/tabulate_stream_checker.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/tabulate_stream_checker_if.sv
// -----------------------------------------------------------------------------
// tabulate_stream_checker_if
//   Element stream between the tabulate generator and its checker.
//   One element moves per cycle in which in_valid and in_ready are both high.
//
//   Signals:
//     in_valid  generator -> checker  element on in_data/in_last is valid
//     in_ready  checker -> generator  checker accepts the element this cycle
//     in_data   generator -> checker  element value (DW bits)
//     in_last   generator -> checker  generator marks the final grid element
//
//   Modports: master = generator side, slave = checker side.
// -----------------------------------------------------------------------------
interface tabulate_stream_checker_if #(
    parameter int DW = 32
) ();
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/tabulate_stream_checker.sv
// -----------------------------------------------------------------------------
// tabulate_stream_checker
//   Sink that consumes a row-major ROWS x COLS element stream and checks every
//   element against row + col + BASE (modulo 2^DW). Reports a saturating
//   mismatch count, the first mismatching element, in_last consistency and a
//   pass/done verdict that holds until the next start.
//
//   Ports:
//     clock      rising-edge clock
//     reset      synchronous, active-low reset
//     start      pulse: begin a new check pass (honoured in IDLE and DONE)
//     hold       back-pressure request, forces in_ready low
//     in_if      element stream (slave side)
//     busy       pass in progress (RUN)
//     done       pass complete, verdict valid (level, DONE)
//     pass       done, no mismatches and no in_last inconsistency
//     err_count  mismatching elements, saturates at all-ones
//     last_err   in_last disagreed with grid position on some beat (sticky)
//     err_row    row of first mismatch
//     err_col    column of first mismatch
//     err_data   data of first mismatch
//     cur_row    row of the next expected element
//     cur_col    column of the next expected element
// -----------------------------------------------------------------------------
module tabulate_stream_checker #(
    parameter  int ROWS = 2,
    parameter  int COLS = 2,
    parameter  int DW   = 32,
    parameter  int BASE = 1,
    parameter  int CW   = 8,
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CLW  = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       hold,
    tabulate_stream_checker_if.slave   in_if,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [CW-1:0]              err_count,
    output logic                       last_err,
    output logic [RW-1:0]              err_row,
    output logic [CLW-1:0]             err_col,
    output logic [DW-1:0]              err_data,
    output logic [RW-1:0]              cur_row,
    output logic [CLW-1:0]             cur_col
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam logic [RW-1:0]  ROW_LAST = RW'(ROWS - 1);
    localparam logic [CLW-1:0] COL_LAST = CLW'(COLS - 1);

    state_e          state_q;
    logic [RW-1:0]   cur_row_q;
    logic [CLW-1:0]  cur_col_q;
    logic [CW-1:0]   err_count_q;
    logic            last_err_q;
    logic            captured_q;
    logic [RW-1:0]   err_row_q;
    logic [CLW-1:0]  err_col_q;
    logic [DW-1:0]   err_data_q;

    logic [RW-1:0]   cur_row_d;
    logic [CLW-1:0]  cur_col_d;
    logic [CW-1:0]   err_count_d;
    logic [DW-1:0]   expected;
    logic            col_wrap;
    logic            is_final;
    logic            handshake;
    logic            mismatch;

    assign col_wrap  = (cur_col_q == COL_LAST);
    assign is_final  = (cur_row_q == ROW_LAST) && col_wrap;
    // Indices are zero-extended to DW before the add, so the sum wraps at 2^DW.
    assign expected  = DW'(cur_row_q) + DW'(cur_col_q) + DW'(BASE);
    assign handshake = in_if.in_valid && in_if.in_ready;
    assign mismatch  = (in_if.in_data != expected);

    // Row-major advance; the final element returns both indices to 0.
    assign cur_col_d   = col_wrap ? '0 : cur_col_q + CLW'(1);
    assign cur_row_d   = is_final ? '0 :
                         (col_wrap ? cur_row_q + RW'(1) : cur_row_q);
    assign err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + CW'(1);

    // in_ready depends only on state and hold so the generator sees back-pressure
    // in the same cycle it is requested.
    assign in_if.in_ready = (state_q == RUN) && !hold;

    // NOTE: reset is synchronous (sampled only on the clock edge), so it is not
    // in the sensitivity list; all state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            cur_row_q   <= '0;
            cur_col_q   <= '0;
            err_count_q <= '0;
            last_err_q  <= 1'b0;
            captured_q  <= 1'b0;
            err_row_q   <= '0;
            err_col_q   <= '0;
            err_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q     <= RUN;
                        cur_row_q   <= '0;
                        cur_col_q   <= '0;
                        err_count_q <= '0;
                        last_err_q  <= 1'b0;
                        captured_q  <= 1'b0;
                        err_row_q   <= '0;
                        err_col_q   <= '0;
                        err_data_q  <= '0;
                    end
                end
                RUN: begin
                    // start is deliberately ignored here: a pass always runs
                    // for exactly ROWS*COLS beats.
                    if (handshake) begin
                        if (mismatch) begin
                            err_count_q <= err_count_d;
                            if (!captured_q) begin
                                captured_q <= 1'b1;
                                err_row_q  <= cur_row_q;
                                err_col_q  <= cur_col_q;
                                err_data_q <= in_if.in_data;
                            end
                        end
                        if (in_if.in_last != is_final) begin
                            last_err_q <= 1'b1;
                        end
                        cur_row_q <= cur_row_d;
                        cur_col_q <= cur_col_d;
                        if (is_final) begin
                            state_q <= DONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign pass      = done && (err_count_q == '0) && !last_err_q;
    assign err_count = err_count_q;
    assign last_err  = last_err_q;
    assign err_row   = err_row_q;
    assign err_col   = err_col_q;
    assign err_data  = err_data_q;
    assign cur_row   = cur_row_q;
    assign cur_col   = cur_col_q;

endmodule
